// File: rtl/alu_fpga.sv
// FPGA wrapper for a 16-bit Hack ALU: preloaded operand memories, registered result,
// zr/ng flags and a 4-digit multiplexed hex display.
module alu_fpga #(
   parameter int REFRESH_BITS = 18
) (
   input  logic        clk,
   input  logic        initialise,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   input  logic [4:0]  address_a,
   input  logic [4:0]  address_b,
   output logic [15:0] result,
   output logic        zr,
   output logic        ng,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   function automatic logic [15:0] preload(input logic [4:0] idx);
      logic [15:0] v;
      case (idx)
         5'd0:  v = 16'h0000;  5'd1:  v = 16'h0001;  5'd2:  v = 16'h0002;  5'd3:  v = 16'h0003;
         5'd4:  v = 16'h0004;  5'd5:  v = 16'h0005;  5'd6:  v = 16'h000F;  5'd7:  v = 16'h0010;
         5'd8:  v = 16'h0080;  5'd9:  v = 16'h00FF;  5'd10: v = 16'h0100;  5'd11: v = 16'h7FFF;
         5'd12: v = 16'hFFFF;  5'd13: v = 16'hFFFE;  5'd14: v = 16'hFFF0;  5'd15: v = 16'hF000;
         5'd16: v = 16'h0F00;  5'd17: v = 16'hFF00;  5'd18: v = 16'h0FF0;  5'd19: v = 16'h8000;
         5'd20: v = 16'h5555;  5'd21: v = 16'hAAAA;  5'd22: v = 16'h0F0F;  5'd23: v = 16'hF0F0;
         5'd24: v = 16'h00F0;  5'd25: v = 16'h1234;  5'd26: v = 16'h4321;  5'd27: v = 16'h3C3C;
         5'd28: v = 16'h0808;  5'd29: v = 16'h8001;  5'd30: v = 16'h7FFE;  default: v = 16'hC000;
      endcase
      return v;
   endfunction

   logic [15:0]             r_mem_a [32];
   logic [15:0]             r_mem_b [32];
   logic [15:0]             r_x;
   logic [15:0]             r_y;
   logic [15:0]             r_result;
   logic [REFRESH_BITS-1:0] r_refresh;

   logic [15:0] w_x1, w_x2, w_y1, w_y2, w_o, w_out;
   logic [1:0]  w_sel;
   logic [3:0]  w_nibble;

   // The memories have no write port other than the reset-time preload.
   always_ff @(posedge clk) begin
      if (initialise) begin
         for (int i = 0; i < 32; i++) begin
            r_mem_a[i] <= preload(5'(i));
            r_mem_b[i] <= preload(5'(i));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (initialise) begin
         r_x       <= '0;
         r_y       <= '0;
         r_result  <= '0;
         r_refresh <= '0;
      end else begin
         r_x       <= r_mem_a[address_a];
         r_y       <= r_mem_b[address_b];
         r_result  <= w_out;
         r_refresh <= r_refresh + 1'b1;
      end
   end

   assign w_x1  = zx ? 16'h0000 : r_x;
   assign w_x2  = nx ? ~w_x1 : w_x1;
   assign w_y1  = zy ? 16'h0000 : r_y;
   assign w_y2  = ny ? ~w_y1 : w_y1;
   assign w_o   = f ? (w_x2 + w_y2) : (w_x2 & w_y2);
   assign w_out = no ? ~w_o : w_o;

   assign result = r_result;
   assign zr     = (r_result == 16'h0000);
   assign ng     = r_result[15];

   assign w_sel = r_refresh[REFRESH_BITS-1 -: 2];

   always_comb begin
      w_nibble = r_result[3:0];
      an       = 4'b1110;
      case (w_sel)
         2'd0: begin w_nibble = r_result[3:0];   an = 4'b1110; end
         2'd1: begin w_nibble = r_result[7:4];   an = 4'b1101; end
         2'd2: begin w_nibble = r_result[11:8];  an = 4'b1011; end
         default: begin w_nibble = r_result[15:12]; an = 4'b0111; end
      endcase
   end

   // Segment order is {g,f,e,d,c,b,a}, lit when low.
   always_comb begin
      seg = 7'b1000000;
      case (w_nibble)
         4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;  4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;  4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;  4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;  4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
      endcase
   end

endmodule

// File: tb/tb_alu_fpga.sv
// Self-checking bench for alu_fpga: directed Hack ALU cases, display scan and random
// traffic compared every cycle against a behavioural model of the datapath and display.
module tb_alu_fpga;
  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        initialise = 1'b1;
  logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
  logic [4:0]  address_a = '0, address_b = '0;
  logic [15:0] result;
  logic        zr, ng;
  logic [6:0]  seg;
  logic [3:0]  an;

  alu_fpga #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .initialise(initialise),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .address_a(address_a), .address_b(address_b),
    .result(result), .zr(zr), .ng(ng), .seg(seg), .an(an)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [15:0] rom [32] = '{
    16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h000F, 16'h0010,
    16'h0080, 16'h00FF, 16'h0100, 16'h7FFF, 16'hFFFF, 16'hFFFE, 16'hFFF0, 16'hF000,
    16'h0F00, 16'hFF00, 16'h0FF0, 16'h8000, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0,
    16'h00F0, 16'h1234, 16'h4321, 16'h3C3C, 16'h0808, 16'h8001, 16'h7FFE, 16'hC000};

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_cmp = 0;
  int n_bad = 0;

  // scoreboard: model state after each edge
  logic [15:0] exp_q [$];
  logic [15:0] m_x = '0, m_y = '0, m_res = '0;
  int          m_clk_since_rst = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] hack(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    int xv, yv, ov;
    xv = c[5] ? 0 : int'(x);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(y);
    if (c[2]) yv = 65535 - yv;
    ov = c[1] ? (xv + yv) % 65536 : (xv & yv);
    if (c[0]) ov = 65535 - ov;
    return 16'(ov);
  endfunction

  // driver: apply inputs, take one edge, update model, check all outputs
  task automatic tick(input logic rst, input logic [4:0] a, input logic [4:0] b, input logic [5:0] c);
    int digit;
    logic [15:0] e;
    initialise = rst;
    address_a = a; address_b = b;
    {zx, nx, zy, ny, f, no} = c;
    @(posedge clk);
    if (rst) begin
      m_x = '0; m_y = '0; m_res = '0; m_clk_since_rst = 0;
    end else begin
      m_res = hack(m_x, m_y, c);
      m_x = rom[a];
      m_y = rom[b];
      m_clk_since_rst++;
    end
    exp_q.push_back(m_res);
    #1;
    e = exp_q.pop_front();
    digit = (m_clk_since_rst % (1 << RB)) / (1 << (RB - 2));
    check_eq("result", result, e);
    check_eq("zr", 16'(zr), (e == 16'h0000) ? 16'd1 : 16'd0);
    check_eq("ng", 16'(ng), (e >= 16'h8000) ? 16'd1 : 16'd0);
    check_eq("an", 16'(an), 16'(4'hF ^ (4'b0001 << digit)));
    check_eq("seg", 16'(seg), 16'(seg_tab[(e / (16'd1 << (4 * digit))) % 16]));
  endtask

  task automatic hold(input logic [4:0] a, input logic [4:0] b, input logic [5:0] c, input int n);
    for (int k = 0; k < n; k++) tick(1'b0, a, b, c);
  endtask

  initial begin
    tick(1'b1, 5'd0, 5'd0, 6'b000000);
    check_eq("reset_an", 16'(an), 16'h000E);
    check_eq("reset_seg", 16'(seg), 16'h0040);

    // ADD, including signed boundary and wrap
    hold(5'd1,  5'd2,  6'b000010, 3);
    hold(5'd11, 5'd19, 6'b000010, 3);
    hold(5'd12, 5'd1,  6'b000010, 3);
    // logic functions
    hold(5'd20, 5'd21, 6'b000000, 3);
    hold(5'd20, 5'd21, 6'b010101, 3);
    hold(5'd22, 5'd23, 6'b000001, 3);
    hold(5'd28, 5'd29, 6'b010101, 3);
    hold(5'd17, 5'd9,  6'b000000, 3);
    // constants and unary
    hold(5'd29, 5'd3,  6'b001100, 3);
    hold(5'd12, 5'd3,  6'b011100, 3);
    hold(5'd7,  5'd30, 6'b101010, 3);
    hold(5'd7,  5'd30, 6'b111111, 3);
    hold(5'd7,  5'd30, 6'b111010, 3);
    // latency: ctrl toggles each cycle, then an address step
    for (int k = 0; k < 6; k++) tick(1'b0, 5'd5, 5'd6, k[0] ? 6'b000000 : 6'b000010);
    hold(5'd26, 5'd6, 6'b000010, 3);
    // display scan on 1234
    hold(5'd25, 5'd0, 6'b001100, 20);
    // multi-edge reset then resume
    tick(1'b1, 5'd25, 5'd25, 6'b000010);
    tick(1'b1, 5'd25, 5'd25, 6'b000010);
    hold(5'd25, 5'd26, 6'b000010, 4);

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 49) == 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           6'($urandom_range(0, 63)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/alu_fpga.md
# alu_fpga

FPGA top-level wrapper around a 16-bit Hack-style ALU. Two on-chip 32×16 operand memories (A and B) are preloaded by reset. They are read at switch-selected addresses and combined under the six Hack control bits. The registered 16-bit result drives LEDs, the zr/ng flags, and a 4-digit multiplexed seven-segment display. It sits directly under the board constraints file, with no parent logic.

## Interface
Parameters:
- REFRESH_BITS, 18: width of the display refresh counter; its top 2 bits select the digit.

Ports:
- clk  in  1  system clock, 100 MHz.
- initialise  in  1  reset; synchronous, active-high. Loads both memories and clears all state.
- zx  in  1  zero x input.
- nx  in  1  negate (bitwise NOT) x after zx.
- zy  in  1  zero y input.
- ny  in  1  negate y after zy.
- f  in  1  1 = add (x+y), 0 = and (x&y).
- no  in  1  bitwise NOT of the function output.
- address_a  in  5  read address into memory A (operand x).
- address_b  in  5  read address into memory B (operand y).
- result  out  16  registered ALU output.
- zr  out  1  1 when result == 0.
- ng  out  1  result[15].
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low; an[3] is the leftmost digit.

## Operation
- Memories A and B hold identical content. Each is loaded only while initialise=1 and has no other write path. Preload table (address: hex value):
  - 0:0000, 1:0001, 2:0002, 3:0003, 4:0004, 5:0005, 6:000F, 7:0010
  - 8:0080, 9:00FF, 10:0100, 11:7FFF, 12:FFFF, 13:FFFE, 14:FFF0, 15:F000
  - 16:0F00, 17:FF00, 18:0FF0, 19:8000, 20:5555, 21:AAAA, 22:0F0F, 23:F0F0
  - 24:00F0, 25:1234, 26:4321, 27:3C3C, 28:0808, 29:8001, 30:7FFE, 31:C000
- Operand registers: x_reg <= A[address_a] and y_reg <= B[address_b] on every clock.
- ALU datapath (combinational on x_reg, y_reg and the live control bits):
  - x1 = zx ? 0 : x_reg; x2 = nx ? ~x1 : x1.
  - y1 = zy ? 0 : y_reg; y2 = ny ? ~y1 : y1.
  - o = f ? (x2 + y2) mod 2^16 : (x2 & y2). Carry is discarded; no overflow flag.
  - out = no ? ~o : o.
- result <= out on every clock. zr and ng decode combinationally from the result register.
- Display:
  - The free-running counter increments each clock and wraps at 2^REFRESH_BITS.
  - Counter bits [MSB:MSB-1] = 0..3 select result nibble [3:0], [7:4], [11:8], [15:12].
  - The selected nibble drives an = 1110, 1101, 1011, 0111 respectively.
  - Hex encoding, active-low {g..a}:
    - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000
    - 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110
- Memory contents are undefined until the first initialise pulse. Initialise must be asserted at least one clock before use.

## Timing
- Reset (initialise=1 at a clock edge), effective the same edge:
  - memories loaded; x_reg, y_reg and result = 0; refresh counter = 0.
  - Resulting outputs: zr=1, ng=0, an=1110, seg=1000000.
- If initialise stays high across multiple edges, the same state is re-applied on each edge. The first operand read occurs on the edge after deassertion.
- Latency:
  - address change to result: 2 clocks (operand register, then result register).
  - control-bit change to result: 1 clock.
- Control bits and addresses may change every cycle; there is no handshake.
- Each digit is held for 2^(REFRESH_BITS-2) clocks (≈655 µs at 100 MHz). Full refresh ≈2.6 ms.
- The displayed value may change mid-scan; there is no display latch.

## Test plan
- Reset: pulse initialise for 1 clock -> result=0000, zr=1, ng=0, an=1110, seg=1000000.
- ADD: a=1, b=2, ctrl 000010 -> after 2 clocks result=0003, zr=0, ng=0. Then a=11 (7FFF), b=19 (8000) -> FFFF, ng=1. Then a=12, b=1 -> 0000 (wrap), zr=1.
- Logic:
  - AND a=20, b=21, ctrl 000000 -> 0000, zr=1.
  - OR ctrl 010101 -> FFFF, ng=1.
  - NAND a=22, b=23, ctrl 000001 -> FFFF.
  - OR a=28, b=29 -> 8809, ng=1.
  - AND a=17, b=9 -> 0000, zr=1.
- Constants/unary:
  - ctrl 001100, a=29 -> 8001 (pass x).
  - ctrl 011100, a=12 -> 0000 (not x).
  - ctrl 101010 -> 0000 regardless of addresses.
  - ctrl 111111 -> 0001.
  - ctrl 111010 -> FFFF.
- Latency: hold addresses and toggle ctrl 000010 -> 000000 -> result changes exactly 1 clock later. Change address_a -> result changes exactly 2 clocks later.
- Display (REFRESH_BITS=4 in sim): result=1234 -> an cycles 1110/1101/1011/0111 every 4 clocks, with seg = 0011001, 0110000, 0100100, 1111001.
